// File: rtl/jpeg_stream_parser.sv
// JPEG byte-stream front end: SOI/EOI framing, marker-segment parsing and ECS unstuffing into one FIFO.
// Optional build macro JPEG_RST_MARKER_EVT_EN: restart markers FFD0-FFD7 inside a scan pulse mrk_valid.
module jpeg_stream_parser #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             jpeg_valid,
  output logic             jpeg_ready,
  input  logic [7:0]       jpeg_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_seg,
  output logic             out_last,
  output logic             mrk_valid,
  output logic [7:0]       mrk_code,
  output logic [CNT_W-1:0] scan_bytes,
  output logic             decode_done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  // Two free slots are kept so the hold byte and the incoming byte always fit.
  localparam logic [AW:0] ReadyMax = (AW+1)'(FIFO_DEPTH - 2);

  localparam logic [1:0] ErrNoSoi     = 2'd1;
  localparam logic [1:0] ErrBadLen    = 2'd2;
  localparam logic [1:0] ErrBadMarker = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StSoiChk, StHdr, StMarker, StLenHi, StLenLo, StSeg, StEcs, StEcsFf, StFlush, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic             mrk_valid_q, mrk_valid_d;
  logic [7:0]       mrk_code_q, mrk_code_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             accept, push, pop, take;
  logic [9:0]       push_data;
  logic [7:0]       take_val;
  logic [15:0]      len_w;
  logic             is_rst_mrk;

  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fifo_cnt_q;

  assign jpeg_ready = rst_n && (fifo_cnt_q <= ReadyMax) && !err_q && !done_q &&
                      (state_q != StFlush) && (state_q != StDone);
  assign accept     = jpeg_valid && jpeg_ready;
  assign len_w      = {len_hi_q, jpeg_data};
  assign is_rst_mrk = (jpeg_data[7:3] == 5'b11010);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    len_hi_d    = len_hi_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    scan_d      = scan_q;
    mrk_valid_d = 1'b0;
    mrk_code_d  = mrk_code_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    push        = 1'b0;
    push_data   = '0;
    take        = 1'b0;
    take_val    = jpeg_data;

    if (accept) begin
      case (state_q)
        StIdle: begin
          if (jpeg_data == 8'hFF) state_d = StSoiChk;
          else begin err_d = 1'b1; err_code_d = ErrNoSoi; end
        end
        StSoiChk: begin
          if (jpeg_data == 8'hD8) state_d = StHdr;
          else begin err_d = 1'b1; err_code_d = ErrNoSoi; end
        end
        StHdr: begin
          if (jpeg_data == 8'hFF) state_d = StMarker;
          else begin err_d = 1'b1; err_code_d = ErrBadMarker; end
        end
        StMarker: begin
          if (jpeg_data == 8'hFF) begin
            state_d = StMarker;
          end else if (jpeg_data == 8'hD9) begin
            state_d = StFlush;
          end else if (jpeg_data == 8'h01) begin
            state_d = StHdr;
          end else if (is_rst_mrk || jpeg_data == 8'hD8) begin
            err_d      = 1'b1;
            err_code_d = ErrBadMarker;
          end else begin
            code_d      = jpeg_data;
            mrk_valid_d = 1'b1;
            mrk_code_d  = jpeg_data;
            state_d     = StLenHi;
          end
        end
        StLenHi: begin
          len_hi_d = jpeg_data;
          state_d  = StLenLo;
        end
        StLenLo: begin
          if (len_w < 16'd2) begin
            err_d      = 1'b1;
            err_code_d = ErrBadLen;
          end else if (len_w == 16'd2) begin
            if (code_q == 8'hDA) begin
              state_d    = StEcs;
              scan_d     = '0;
              hold_vld_d = 1'b0;
            end else begin
              state_d = StHdr;
            end
          end else begin
            cnt_d   = len_w - 16'd2;
            state_d = StSeg;
          end
        end
        StSeg: begin
          push      = 1'b1;
          push_data = {1'b1, cnt_q == 16'd1, jpeg_data};
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            if (code_q == 8'hDA) begin
              state_d    = StEcs;
              scan_d     = '0;
              hold_vld_d = 1'b0;
            end else begin
              state_d = StHdr;
            end
          end
        end
        StEcs: begin
          if (jpeg_data == 8'hFF) state_d = StEcsFf;
          else take = 1'b1;
        end
        StEcsFf: begin
          if (jpeg_data == 8'h00) begin
            take     = 1'b1;
            take_val = 8'hFF;
            state_d  = StEcs;
          end else if (jpeg_data == 8'hFF) begin
            state_d = StEcsFf;
          end else if (is_rst_mrk) begin
`ifdef JPEG_RST_MARKER_EVT_EN
            mrk_valid_d = 1'b1;
            mrk_code_d  = jpeg_data;
`endif
            state_d = StEcs;
          end else begin
            // End of scan: the held byte is the final ECS byte.
            if (hold_vld_q) begin
              push      = 1'b1;
              push_data = {1'b0, 1'b1, hold_q};
            end
            hold_vld_d = 1'b0;
            if (jpeg_data == 8'hD9) begin
              state_d = StFlush;
            end else begin
              code_d      = jpeg_data;
              mrk_valid_d = 1'b1;
              mrk_code_d  = jpeg_data;
              state_d     = StLenHi;
            end
          end
        end
        default: ;
      endcase
    end

    // One-byte delay so the last ECS byte can be tagged when the end marker arrives.
    if (take) begin
      if (hold_vld_q) begin
        push      = 1'b1;
        push_data = {1'b0, 1'b0, hold_q};
      end
      hold_d     = take_val;
      hold_vld_d = 1'b1;
      if (scan_q != {CNT_W{1'b1}}) scan_d = scan_q + 1'b1;
    end

    if (state_q == StFlush && fifo_cnt_q == '0) begin
      state_d = StDone;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      code_q      <= '0;
      len_hi_q    <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      scan_q      <= '0;
      mrk_valid_q <= 1'b0;
      mrk_code_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else if (start) begin
      state_q     <= StIdle;
      code_q      <= '0;
      len_hi_q    <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      scan_q      <= '0;
      mrk_valid_q <= 1'b0;
      mrk_code_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      len_hi_q    <= len_hi_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      scan_q      <= scan_d;
      mrk_valid_q <= mrk_valid_d;
      mrk_code_q  <= mrk_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push && !start) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

  assign out_data    = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign out_last    = out_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
  assign out_seg     = out_valid ? mem_q[rd_ptr_q][9]   : 1'b0;
  assign mrk_valid   = mrk_valid_q;
  assign mrk_code    = mrk_code_q;
  assign scan_bytes  = scan_q;
  assign decode_done = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_jpeg_stream_parser.sv
// Scoreboard bench for jpeg_stream_parser: directed streams, queued expectations, decoupled monitor.
module tb_jpeg_stream_parser;

  localparam int unsigned FD = 16;
  localparam int unsigned CW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          jpeg_valid = 1'b0;
  logic          jpeg_ready;
  logic [7:0]    jpeg_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_seg;
  logic          out_last;
  logic          mrk_valid;
  logic [7:0]    mrk_code;
  logic [CW-1:0] scan_bytes;
  logic          decode_done;
  logic          err;
  logic [1:0]    err_code;

  jpeg_stream_parser #(.FIFO_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .jpeg_valid(jpeg_valid), .jpeg_ready(jpeg_ready), .jpeg_data(jpeg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_seg(out_seg), .out_last(out_last),
    .mrk_valid(mrk_valid), .mrk_code(mrk_code), .scan_bytes(scan_bytes),
    .decode_done(decode_done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];   // {seg, last, data}
  logic [7:0] mrk_q[$];
  logic [7:0] stim[$];
  int checks = 0;
  int errors = 0;
  int accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && !start && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", {out_seg, out_last, out_data});
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({out_seg, out_last, out_data} !== e) begin
          errors++;
          $display("FAIL out_entry: got %0h expected %0h", {out_seg, out_last, out_data}, e);
        end
      end
    end
    if (rst_n && mrk_valid) begin
      checks++;
      if (mrk_q.size() == 0) begin
        errors++;
        $display("FAIL mrk_unexpected: got %0h expected none", mrk_code);
      end else begin
        logic [7:0] m;
        m = mrk_q.pop_front();
        if (mrk_code !== m) begin
          errors++;
          $display("FAIL mrk_code: got %0h expected %0h", mrk_code, m);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    jpeg_data  = b;
    jpeg_valid = 1'b1;
    @(negedge clk);
    while (!jpeg_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!jpeg_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", b);
      jpeg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    jpeg_valid = 1'b0;
    accepted++;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send(stim[i]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!decode_done && n < 300) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("decode_done", decode_done, 1);
  endtask

  task automatic restart();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    accepted = 0;
    stim.delete();
    chk("start_clears_done", decode_done, 0);
    chk("start_ready", jpeg_ready, 1);
  endtask

  task automatic queues_empty(input string name);
    chk({name, "_out_q"}, exp_q.size(), 0);
    chk({name, "_mrk_q"}, mrk_q.size(), 0);
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", jpeg_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_done", decode_done, 0);
    chk("rst_scan", scan_bytes, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", jpeg_ready, 1);

    // Test 1: DQT segment with two payload bytes
    mrk_q.push_back(8'hDB);
    exp_q.push_back({2'b10, 8'hAA});
    exp_q.push_back({2'b11, 8'hBB});
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hFF, 8'hD9};
    foreach (stim[i]) begin
      send(stim[i]);
      if (i == 6) chk("seg_latency", out_valid, 1);
    end
    wait_done();
    chk("t1_err", err, 0);
    chk("t1_ready_done", jpeg_ready, 0);
    queues_empty("t1");

    // Test 2: SOS with one payload byte, stuffed FF in ECS
    restart();
    mrk_q.push_back(8'hDA);
    exp_q.push_back({2'b11, 8'h01});
    exp_q.push_back({2'b00, 8'h12});
    exp_q.push_back({2'b00, 8'hFF});
    exp_q.push_back({2'b01, 8'h34});
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h03, 8'h01, 8'h12, 8'hFF, 8'h00,
             8'h34, 8'hFF, 8'hD9};
    foreach (stim[i]) begin
      send(stim[i]);
      if (i == 7) chk("ecs_held", out_valid, 0);
    end
    wait_done();
    chk("t2_scan_bytes", scan_bytes, 3);
    chk("t2_err", err, 0);
    queues_empty("t2");

    // Test 3: missing SOI
    restart();
    send(8'h00);
    chk("t3_err", err, 1);
    chk("t3_err_code", err_code, 1);
    chk("t3_ready", jpeg_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_out_valid", out_valid, 0);

    // Test 4: length below 2
    restart();
    mrk_q.push_back(8'hC0);
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hC0, 8'h00, 8'h01};
    send_stim();
    chk("t4_err_code", {err, err_code}, 3'b110);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_frozen_ready", jpeg_ready, 0);
    chk("t4_err_sticky", err, 1);
    chk("t4_out_valid", out_valid, 0);
    chk("t4_done", decode_done, 0);
    queues_empty("t4");

    // Test 5: restart marker inside ECS
    restart();
    mrk_q.push_back(8'hDA);
`ifdef JPEG_RST_MARKER_EVT_EN
    mrk_q.push_back(8'hD0);
`endif
    exp_q.push_back({2'b00, 8'h12});
    exp_q.push_back({2'b01, 8'h34});
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h02, 8'h12, 8'hFF, 8'hD0, 8'h34,
             8'hFF, 8'hD9};
    send_stim();
    wait_done();
    chk("t5_scan_bytes", scan_bytes, 2);
    queues_empty("t5");

    // Test 6: 20-byte segment with output stalled; input must back off at FD-1 used
    restart();
    mrk_q.push_back(8'hDB);
    stim = '{8'hFF, 8'hD8, 8'hFF, 8'hDB, 8'h00, 8'h16};
    for (int i = 0; i < 20; i++) begin
      stim.push_back(8'(8'h40 + i));
      exp_q.push_back({1'b1, (i == 19), 8'(8'h40 + i)});
    end
    stim.push_back(8'hFF);
    stim.push_back(8'hD9);
    out_ready = 1'b0;
    fork
      send_stim();
      begin
        repeat (40) @(posedge clk);
        #2;
        chk("t6_ready_stalled", jpeg_ready, 0);
        chk("t6_accepted_stalled", accepted, 21);
        chk("t6_out_valid_stalled", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_done();
    chk("t6_err", err, 0);
    queues_empty("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
